note_source: RTL and testbench
==============================

NOTE_SOURCE -- requirements
Module: note_source

Interface
REQ-001 Parameter STEP_CYCLES, default 4; Clock cycles per column step, legal range 2..65535.
REQ-002 Parameter DENSITY, default 4; emit threshold, legal range 0..8 (0 = never emit, 8 = emit on every armed step).
REQ-003 Parameter MIN_GAP, default 1; number of forced-empty steps after each emitting step, legal range 0..7.
REQ-004 Parameter SEED, default 8'hA5; LFSR load value, SHALL be nonzero.
REQ-005 Clock  in  1  single system clock; all state SHALL be updated on its rising edge.
REQ-006 Reset  in  1  asynchronous, active-low; Reset=0 SHALL reset all state immediately.
REQ-007 enable  in  1  run request; while low, no steps are generated.
REQ-008 set  in  1  synchronous game restart; same effect as reset, applied at the next Clock edge.
REQ-009 step  out  1  single-cycle column-shift strobe for the light columns.
REQ-010 lane_out  out  4  note pattern injected at the top of lanes 0..3; held stable between steps.
REQ-011 notes_issued  out  8  count of emitting steps, saturating.

Function
REQ-012 Prescaler SHALL count 0..STEP_CYCLES-1 while enable=1 and SHALL hold its value while enable=0.
REQ-013 step SHALL be 1 for exactly the one cycle in which the prescaler holds STEP_CYCLES-1 and enable=1, then the prescaler wraps to 0.
REQ-014 The first step after reset SHALL occur STEP_CYCLES cycles after the first enabled edge.
REQ-015 An 8-bit Fibonacci LFSR (taps 8,6,5,4; shift left; feedback into bit 0) SHALL advance only on step.
REQ-016 The FSM SHALL have states IDLE, ARMED and GAP; all transitions SHALL occur only on step, except reset and set.
REQ-017 IDLE -> ARMED on the first step; IDLE SHALL emit nothing.
REQ-018 In ARMED on step: emit if lfsr[2:0] < DENSITY (3-bit value zero-extended); otherwise stay in ARMED with lane_out=0.
REQ-019 Emit: lane_out SHALL be one-hot at index lfsr[4:3]. If lfsr[7:5]==3'b111, bit (lfsr[4:3]+2) mod 4 SHALL also be set.
REQ-020 After an emit, the FSM SHALL go to GAP if MIN_GAP>0, otherwise remain in ARMED.
REQ-021 GAP SHALL force lane_out=0 for MIN_GAP steps, counted by a 3-bit gap counter, then return to ARMED.
REQ-022 lane_out SHALL be registered: it updates on the edge that samples step=1 and holds until the next step.
REQ-023 The LFSR value used by REQ-018/019 SHALL be the pre-advance value on that step.
REQ-024 notes_issued SHALL increment by 1 per emitting step, regardless of single or double pattern, and saturate at 255.
REQ-025 enable deasserted mid-operation SHALL freeze the FSM, LFSR, gap counter and prescaler, and SHALL leave lane_out held.
REQ-026 set and reset SHALL take priority over step in the same cycle.

Reset
REQ-027 Reset=0 or set=1 SHALL force the following values: step=0, lane_out=4'b0000, notes_issued=0, prescaler=0, gap counter=0, LFSR=SEED, FSM=IDLE.
REQ-028 Reset deassertion SHALL require no synchronizer inside this block; the top level provides a synchronized release.

Structure
REQ-029 Package dance_pkg SHALL hold: NUM_LANES=4, the LFSR tap mask, the default SEED, and the FSM state enum (IDLE, ARMED, GAP).
REQ-030 The LFSR SHALL be a sub-module named lfsr8 (ports: Clock, Reset, load, seed, advance, value).
REQ-031 The prescaler, FSM and output registers SHALL reside in note_source; target size is 120-400 RTL lines.

Verification
REQ-032 Reset: hold Reset=0 for 3 cycles with enable=1 -> step=0, lane_out=0, notes_issued=0 throughout; the first step occurs 4 cycles after release.
REQ-033 DENSITY=8, MIN_GAP=0, enable=1 for 20 steps -> first step IDLE with lane_out=0; each of the following 19 steps emits a pattern matching the reference LFSR model from A5; notes_issued=19.
REQ-034 DENSITY=8, MIN_GAP=2 -> step patterns follow the sequence IDLE, emit, 0, 0, emit, 0, 0, emit; notes_issued increments every 3rd step.
REQ-035 DENSITY=0 for 50 steps -> lane_out stays 0 and notes_issued=0; the LFSR still advances (checked by probing lfsr8 value).
REQ-036 enable dropped for 10 cycles mid-GAP -> no step pulses, and lane_out, the gap counter and the prescaler hold; sequence resumes identically after re-enable.
REQ-037 Saturation and set: force 300 emits -> notes_issued=255; set=1 coincident with step -> no step effect, and all REQ-027 values appear on the next cycle.

Source files
------------

// File: rtl/dance_pkg.sv
// -----------------------------------------------------------------------------
// dance_pkg
// Shared constants and types for the note source slice:
//   NUM_LANES     - number of light lanes fed by the note source
//   LFSR_TAPS     - tap mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
//   DEFAULT_SEED  - power-up / restart value of the LFSR
//   state_t       - note source FSM states
//   note_pattern  - maps a pre-advance LFSR value to a lane pattern
// -----------------------------------------------------------------------------
package dance_pkg;

   localparam int unsigned NUM_LANES    = 4;
   localparam logic [7:0]  LFSR_TAPS    = 8'b1011_1000;
   localparam logic [7:0]  DEFAULT_SEED = 8'hA5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      GAP   = 2'd2
   } state_t;

   // One-hot lane at v[4:3]; when v[7:5] is all ones the lane two positions
   // away (mod 4) lights as well, giving a double note.
   function automatic logic [NUM_LANES-1:0] note_pattern(input logic [7:0] v);
      logic [1:0]           idx;
      logic [1:0]           mirror;
      logic [NUM_LANES-1:0] pat;
      idx    = v[4:3];
      mirror = idx + 2'd2;
      pat    = '0;
      pat[idx] = 1'b1;
      if (&v[7:5]) begin
         pat[mirror] = 1'b1;
      end
      return pat;
   endfunction

endpackage

// File: rtl/lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// 8-bit Fibonacci LFSR, shift left with feedback into bit 0.
// Ports:
//   Clock   - system clock, rising edge
//   Reset   - asynchronous active-low reset, loads RESET_VALUE
//   load    - synchronous load of seed (wins over advance)
//   seed    - value loaded by load
//   advance - shift one position this cycle
//   value   - current register contents
// -----------------------------------------------------------------------------
module lfsr8
   import dance_pkg::*;
#(
   parameter logic [7:0] RESET_VALUE = DEFAULT_SEED
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       advance,
   output logic [7:0] value
);

   logic [7:0] r_value;
   logic       w_feedback;

   assign w_feedback = ^(r_value & LFSR_TAPS);
   assign value      = r_value;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_value <= RESET_VALUE;
      end else if (load) begin
         r_value <= seed;
      end else if (advance) begin
         r_value <= {r_value[6:0], w_feedback};
      end
   end

endmodule

// File: rtl/note_source.sv
// -----------------------------------------------------------------------------
// note_source
// Generates the note pattern injected at the top of the four light lanes.
// A prescaler produces a column-step strobe every STEP_CYCLES enabled cycles;
// on each step an LFSR-driven FSM decides whether to emit a note.
// Ports:
//   Clock        - system clock, rising edge
//   Reset        - asynchronous active-low reset
//   enable       - run request; low freezes all state
//   set          - synchronous restart, same effect as Reset
//   step         - single-cycle column-shift strobe
//   lane_out     - registered note pattern, held between steps
//   notes_issued - saturating count of emitting steps
// -----------------------------------------------------------------------------
module note_source
   import dance_pkg::*;
#(
   parameter int unsigned STEP_CYCLES = 4,
   parameter int unsigned DENSITY     = 4,
   parameter int unsigned MIN_GAP     = 1,
   parameter logic [7:0]  SEED        = DEFAULT_SEED
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 enable,
   input  logic                 set,
   output logic                 step,
   output logic [NUM_LANES-1:0] lane_out,
   output logic [7:0]           notes_issued
);

   localparam logic [15:0] PRESC_MAX   = 16'(STEP_CYCLES - 1);
   localparam logic [3:0]  DENSITY_CMP = 4'(DENSITY);
   localparam logic [2:0]  GAP_LOAD    = 3'(MIN_GAP);

   logic [15:0]          r_presc;
   state_t               r_state;
   logic [2:0]           r_gap_cnt;
   logic [NUM_LANES-1:0] r_lane;
   logic [7:0]           r_notes;

   logic                 w_step;
   logic                 w_hit;
   logic                 w_emit;
   logic [7:0]           w_lfsr;
   state_t               w_state_nxt;
   logic [2:0]           w_gap_nxt;
   logic [NUM_LANES-1:0] w_lane_nxt;

   // step is gated by set so a restart landing on a step edge has no step effect
   assign w_step       = enable & ~set & (r_presc == PRESC_MAX);
   assign step         = w_step;
   assign lane_out     = r_lane;
   assign notes_issued = r_notes;

   // Emit decision uses the pre-advance LFSR value; it shifts on this same edge
   assign w_hit = ({1'b0, w_lfsr[2:0]} < DENSITY_CMP);

   lfsr8 #(
      .RESET_VALUE(SEED)
   ) u_lfsr (
      .Clock  (Clock),
      .Reset  (Reset),
      .load   (set),
      .seed   (SEED),
      .advance(w_step),
      .value  (w_lfsr)
   );

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_presc <= '0;
      end else if (set) begin
         r_presc <= '0;
      end else if (enable) begin
         if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + 16'd1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap_cnt;
      w_lane_nxt  = r_lane;
      w_emit      = 1'b0;
      if (w_step) begin
         w_lane_nxt = '0;
         case (r_state)
            IDLE: begin
               w_state_nxt = ARMED;
            end
            ARMED: begin
               if (w_hit) begin
                  w_emit     = 1'b1;
                  w_lane_nxt = note_pattern(w_lfsr);
                  if (MIN_GAP > 0) begin
                     w_state_nxt = GAP;
                     w_gap_nxt   = GAP_LOAD;
                  end
               end
            end
            GAP: begin
               if (r_gap_cnt <= 3'd1) begin
                  w_state_nxt = ARMED;
                  w_gap_nxt   = '0;
               end else begin
                  w_gap_nxt = r_gap_cnt - 3'd1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_gap_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state   <= IDLE;
         r_gap_cnt <= '0;
         r_lane    <= '0;
         r_notes   <= '0;
      end else if (set) begin
         r_state   <= IDLE;
         r_gap_cnt <= '0;
         r_lane    <= '0;
         r_notes   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_gap_cnt <= w_gap_nxt;
         r_lane    <= w_lane_nxt;
         if (w_emit && (r_notes != 8'hFF)) begin
            r_notes <= r_notes + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_note_source.sv
// -----------------------------------------------------------------------------
// tb_note_source
// Three note_source instances share clock, reset, enable and set:
//   dut_a: DENSITY=8, MIN_GAP=0   dut_b: DENSITY=8, MIN_GAP=2
//   dut_c: DENSITY=0, MIN_GAP=1
// A bench model predicts every step; the expected result is queued per
// instance and a monitor pops and compares whenever an instance steps.
// -----------------------------------------------------------------------------
module tb_note_source;
   import dance_pkg::*;

   typedef struct {
      int         eidx;
      logic [3:0] lane;
      logic [7:0] notes;
      logic [7:0] lfsr;
   } exp_t;

   localparam int DENS [3] = '{8, 8, 0};
   localparam int GAPS [3] = '{0, 2, 1};
   localparam logic [7:0] LFSR_HAND [4] = '{8'h4A, 8'h95, 8'h2A, 8'h54};
   localparam logic [7:0] EMIT_HAND = 8'b1001_0010;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       set;
   logic       w_step  [3];
   logic [3:0] w_lane  [3];
   logic [7:0] w_notes [3];
   logic [7:0] w_lfsr  [3];

   always #5 clk = ~clk;

   note_source #(.STEP_CYCLES(4), .DENSITY(8), .MIN_GAP(0), .SEED(8'hA5)) dut_a (
      .Clock(clk), .Reset(rst_n), .enable(enable), .set(set),
      .step(w_step[0]), .lane_out(w_lane[0]), .notes_issued(w_notes[0]));
   note_source #(.STEP_CYCLES(4), .DENSITY(8), .MIN_GAP(2), .SEED(8'hA5)) dut_b (
      .Clock(clk), .Reset(rst_n), .enable(enable), .set(set),
      .step(w_step[1]), .lane_out(w_lane[1]), .notes_issued(w_notes[1]));
   note_source #(.STEP_CYCLES(4), .DENSITY(0), .MIN_GAP(1), .SEED(8'hA5)) dut_c (
      .Clock(clk), .Reset(rst_n), .enable(enable), .set(set),
      .step(w_step[2]), .lane_out(w_lane[2]), .notes_issued(w_notes[2]));

   assign w_lfsr[0] = dut_a.u_lfsr.value;
   assign w_lfsr[1] = dut_b.u_lfsr.value;
   assign w_lfsr[2] = dut_c.u_lfsr.value;

   int n_pass  = 0;
   int n_total = 0;

   // Bench model state
   int         ecount = 0;
   int         mpresc = 0;
   int         mstate [3];
   int         mgcnt  [3];
   logic [7:0] mlfsr  [3];
   logic [3:0] mlane  [3];
   int         mnotes [3];
   int         mraw   [3] = '{0, 0, 0};
   exp_t       q [3][$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_step(input int m);
      logic [7:0] v;
      int         idx;
      v = mlfsr[m];
      mlane[m] = 4'b0000;
      if (mstate[m] == 0) begin
         mstate[m] = 1;
      end else if (mstate[m] == 1) begin
         if (int'(v[2:0]) < DENS[m]) begin
            idx = int'(v[4:3]);
            mlane[m] = 4'b0001 << idx;
            if (v[7:5] == 3'b111) mlane[m] = mlane[m] | (4'b0001 << ((idx + 2) % 4));
            if (mnotes[m] < 255) mnotes[m]++;
            mraw[m]++;
            if (GAPS[m] > 0) begin
               mstate[m] = 2;
               mgcnt[m]  = GAPS[m];
            end
         end
      end else begin
         mgcnt[m] = mgcnt[m] - 1;
         if (mgcnt[m] == 0) mstate[m] = 1;
      end
      mlfsr[m] = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      q[m].push_back('{eidx: ecount, lane: mlane[m], notes: 8'(mnotes[m]), lfsr: mlfsr[m]});
   endtask

   task automatic model_edge();
      ecount++;
      if (!rst_n || set) begin
         mpresc = 0;
         for (int m = 0; m < 3; m++) begin
            mstate[m] = 0; mgcnt[m] = 0; mlfsr[m] = 8'hA5; mlane[m] = 4'b0000; mnotes[m] = 0;
         end
      end else if (enable) begin
         if (mpresc == 3) begin
            mpresc = 0;
            for (int m = 0; m < 3; m++) model_step(m);
         end else begin
            mpresc++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   // Monitor: samples just ahead of each rising edge
   logic pend      [3] = '{1'b0, 1'b0, 1'b0};
   int   pend_edge [3];
   int   c_steps = 0;
   int   b_steps = 0;
   exp_t mon_e;

   initial begin
      forever begin
         @(negedge clk);
         #3;
         for (int m = 0; m < 3; m++) begin
            if (pend[m]) begin
               pend[m] = 1'b0;
               if (q[m].size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_step dut%0d: step at edge %0d, expected none", m, pend_edge[m]);
               end else begin
                  mon_e = q[m].pop_front();
                  chk($sformatf("step_edge_dut%0d", m), 32'(pend_edge[m]), 32'(mon_e.eidx));
                  chk($sformatf("lane_out_dut%0d", m), 32'(w_lane[m]), 32'(mon_e.lane));
                  chk($sformatf("notes_dut%0d", m), 32'(w_notes[m]), 32'(mon_e.notes));
                  if (m == 2) begin
                     chk("lfsr_model_dut2", 32'(w_lfsr[2]), 32'(mon_e.lfsr));
                     if (c_steps < 4) chk("lfsr_hand_dut2", 32'(w_lfsr[2]), 32'(LFSR_HAND[c_steps]));
                     c_steps++;
                  end
                  if (m == 1 && b_steps < 8) begin
                     chk("emit_seq_dut1", 32'(w_lane[1] != 4'b0000), 32'(EMIT_HAND[b_steps]));
                     b_steps++;
                  end
               end
            end
            if (w_step[m]) begin
               pend[m]      = 1'b1;
               pend_edge[m] = ecount + 1;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_total);
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      rst_n  = 1'b0;
      enable = 1'b1;
      set    = 1'b0;

      // Reset held with enable high: all outputs quiet
      repeat (3) begin
         tick();
         for (int m = 0; m < 3; m++) begin
            chk("reset_step", 32'(w_step[m]), 32'd0);
            chk("reset_lane", 32'(w_lane[m]), 32'd0);
            chk("reset_notes", 32'(w_notes[m]), 32'd0);
         end
      end
      rst_n = 1'b1;

      // First step lands in the fourth cycle after release
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("first_step_cyc%0d", k), 32'(w_step[0]), (k == 3) ? 32'd1 : 32'd0);
         if (k < 3) tick();
      end

      // Run to 20 steps: dut_a emits on all but the first
      guard = 0;
      while (ecount < 3 + 80 && guard < 200) begin
         tick();
         guard++;
      end
      chk("notes_after_20_steps_dut0", 32'(w_notes[0]), 32'd19);
      chk("notes_after_20_steps_dut2", 32'(w_notes[2]), 32'd0);

      // Drop enable for 10 cycles while dut_b is in GAP
      guard = 0;
      while (!(mstate[1] == 2 && mpresc == 1) && guard < 200) begin
         tick();
         guard++;
      end
      chk("reached_gap_dut1", 32'(mstate[1] == 2 && mpresc == 1), 32'd1);
      enable = 1'b0;
      repeat (10) begin
         tick();
         chk("hold_step_dut1", 32'(w_step[1]), 32'd0);
         chk("hold_lane_dut1", 32'(w_lane[1]), 32'(mlane[1]));
         chk("hold_gap_dut1", 32'(dut_b.r_gap_cnt), 32'(mgcnt[1]));
         chk("hold_presc_dut1", 32'(dut_b.r_presc), 32'(mpresc));
      end
      enable = 1'b1;

      // Saturation: drive dut_a to 300 emits
      guard = 0;
      while (mraw[0] < 300 && guard < 5000) begin
         tick();
         guard++;
      end
      chk("notes_saturated_dut0", 32'(w_notes[0]), 32'd255);

      // set coincident with a step
      guard = 0;
      while (mpresc != 3 && guard < 8) begin
         tick();
         guard++;
      end
      set = 1'b1;
      #1;
      chk("set_blocks_step", 32'(w_step[0]), 32'd0);
      tick();
      chk("set_lane_dut0", 32'(w_lane[0]), 32'd0);
      chk("set_notes_dut0", 32'(w_notes[0]), 32'd0);
      chk("set_presc_dut0", 32'(dut_a.r_presc), 32'd0);
      chk("set_lfsr_dut0", 32'(w_lfsr[0]), 32'hA5);
      chk("set_gap_dut1", 32'(dut_b.r_gap_cnt), 32'd0);
      chk("set_state_dut1", 32'(dut_b.r_state), 32'(IDLE));
      chk("set_notes_dut1", 32'(w_notes[1]), 32'd0);
      set = 1'b0;

      // Restart runs, then drain outstanding steps
      repeat (40) tick();
      enable = 1'b0;
      repeat (4) tick();
      for (int m = 0; m < 3; m++) chk($sformatf("missing_steps_dut%0d", m), 32'(q[m].size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
